// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of pending register-file writes
// with youngest-entry forwarding onto the two decoder read ports.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_reg,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic                       wr_en,
  output logic [AW-1:0]              write_reg,
  output logic [DW-1:0]              write_data,
  input  logic [AW-1:0]              rd_addr1,
  input  logic [AW-1:0]              rd_addr2,
  input  logic [DW-1:0]              rf_data1,
  input  logic [DW-1:0]              rf_data2,
  output logic [DW-1:0]              fwd_data1,
  output logic [DW-1:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt;
  logic          push;
  logic          pop;

  logic [AW-1:0] ent_reg  [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  assign count    = cnt;
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign wr_en    = drain_en && !empty;

  // writes to r0 are handshaken but dropped
  assign push = in_valid && in_ready && (in_reg != '0);
  assign pop  = wr_en;

  assign write_reg  = empty ? '0 : ent_reg[head];
  assign write_data = empty ? '0 : ent_data[head];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // entry storage needs no reset; validity comes from head/count
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[tail]  <= in_reg;
      ent_data[tail] <= in_data;
    end
  end

  // scan oldest to youngest so the last hit wins
  function automatic logic [DW-1:0] lookup(
    input logic [AW-1:0] a,
    input logic [DW-1:0] rf
  );
    logic [DW-1:0] v;
    logic [PW-1:0] idx;
    v = rf;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (a != '0 && (PW+1)'(i) < cnt && ent_reg[idx] == a)
        v = ent_data[idx];
    end
    return v;
  endfunction

  // forwarded read data for both decoder ports
  always_comb begin
    fwd_data1 = lookup(rd_addr1, rf_data1);
    fwd_data2 = lookup(rd_addr2, rf_data2);
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic        wr_en;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [2:0]  rd_addr1, rd_addr2;
  logic [15:0] rf_data1, rf_data2;
  logic [15:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        full, empty;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];

  wb_queue #(.DEPTH(DEPTH), .DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en), .wr_en(wr_en),
    .write_reg(write_reg), .write_data(write_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mfwd(logic [2:0] a, logic [15:0] rf);
    logic [15:0] v;
    v = rf;
    if (a != 3'd0)
      foreach (q[i]) if (q[i].r == a) v = q[i].d;
    return v;
  endfunction

  // reference model: a plain queue updated at each rising edge
  always @(posedge clk) begin
    bit acc;
    bit drn;
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = in_valid && q.size() < DEPTH && in_reg != 3'd0;
      drn = drain_en && q.size() > 0;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{r: in_reg, d: in_data});
    end
  end

  // compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (en) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("m_wr_en", 32'(wr_en), 32'(drain_en && q.size() > 0));
      chk("m_write_reg", 32'(write_reg),
          q.size() > 0 ? 32'(q[0].r) : 32'd0);
      chk("m_write_data", 32'(write_data),
          q.size() > 0 ? 32'(q[0].d) : 32'd0);
      chk("m_fwd1", 32'(fwd_data1), 32'(mfwd(rd_addr1, rf_data1)));
      chk("m_fwd2", 32'(fwd_data2), 32'(mfwd(rd_addr2, rf_data2)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [2:0] r, logic [15:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_d;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    drain_en = 1'b0;
    rd_addr1 = 3'd5;
    rd_addr2 = 3'd6;
    rf_data1 = 16'h0005;
    rf_data2 = 16'h0606;
    step();
    step();
    en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_write_data", 32'(write_data), 32'd0);
    rst_n = 1'b1;
    step();

    // single write with drain available
    drain_en = 1'b1;
    push(3'd3, 16'h00AA);
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_reg", 32'(write_reg), 32'd3);
    chk("single_data", 32'(write_data), 32'h00AA);
    step();
    chk("single_empty", 32'(empty), 32'd1);
    drain_en = 1'b0;

    // fill, stall, then drain in order
    for (int i = 1; i <= 4; i++) push(3'(i), 16'(16'h1000 + i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    push(3'd7, 16'hBEEF);
    chk("fill_no_5th", 32'(count), 32'd4);
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_reg", 32'(write_reg), 32'(i));
      chk("drain_data", 32'(write_data), 32'(16'h1000 + i));
      step();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    drain_en = 1'b0;

    // youngest-entry forwarding
    push(3'd5, 16'h1111);
    push(3'd5, 16'h2222);
    chk("fwd_youngest", 32'(fwd_data1), 32'h2222);
    chk("fwd_miss", 32'(fwd_data2), 32'h0606);
    rd_addr2 = 3'd5;
    rf_data2 = 16'h0A0A;
    #1;
    chk("fwd_port2", 32'(fwd_data2), 32'h2222);
    drain_en = 1'b1;
    step();
    chk("fwd_after_pop", 32'(fwd_data1), 32'h2222);
    step();
    chk("fwd_drained", 32'(fwd_data1), 32'h0005);
    rd_addr1 = 3'd0;
    rd_addr2 = 3'd6;
    drain_en = 1'b0;
    push(3'd6, 16'h6666);
    chk("fwd_r0", 32'(fwd_data1), 32'h0005);
    chk("fwd_r6", 32'(fwd_data2), 32'h6666);
    rd_addr1 = 3'd5;
    drain_en = 1'b1;
    step();
    drain_en = 1'b0;

    // register 0 is discarded
    drain_en = 1'b1;
    in_valid = 1'b1;
    in_reg   = 3'd0;
    in_data  = 16'hFFFF;
    #1;
    chk("r0_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_wr_en", 32'(wr_en), 32'd0);
    drain_en = 1'b0;

    // steady push+pop at count 2 across pointer wrap
    push(3'd1, 16'h2001);
    push(3'd2, 16'h2002);
    drain_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k == 0) ? 16'h2001 :
              (k == 1) ? 16'h2002 : 16'(16'h3000 + k - 2);
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_data", 32'(write_data), 32'(exp_d));
      push(3'((k % 7) + 1), 16'(16'h3000 + k));
    end
    chk("pp_count_end", 32'(count), 32'd2);
    step();
    step();
    chk("pp_empty", 32'(empty), 32'd1);
    drain_en = 1'b0;

    // reset with entries pending
    push(3'd5, 16'h5151);
    push(3'd6, 16'h6161);
    push(3'd7, 16'h7171);
    chk("mid_count3", 32'(count), 32'd3);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_reg   = 3'd4;
    in_data  = 16'h4444;
    drain_en = 1'b1;
    step();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_wr_en", 32'(wr_en), 32'd0);
    chk("mid_fwd1", 32'(fwd_data1), 32'(rf_data1));
    chk("mid_fwd2", 32'(fwd_data2), 32'(rf_data2));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of pending-write entries; power of two, at least 2.
REQ-002 Parameter DW, default 16: data width; matches register-file data width.
REQ-003 Parameter AW, default 3: register-address width, giving 8 registers.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 in_valid  input  1  producer has a write-back request.
REQ-007 in_ready  output  1  queue can accept a request this cycle.
REQ-008 in_reg  input  AW  destination register of the request.
REQ-009 in_data  input  DW  write-back value.
REQ-010 drain_en  input  1  register-file write port is available this cycle.
REQ-011 wr_en  output  1  write strobe to the register-file write port.
REQ-012 write_reg  output  AW  register-file write address.
REQ-013 write_data  output  DW  register-file write data.
REQ-014 rd_addr1, rd_addr2  input  AW each  register-file read addresses driven by the decoder.
REQ-015 rf_data1, rf_data2  input  DW each  raw register-file read data for rd_addr1 and rd_addr2.
REQ-016 fwd_data1, fwd_data2  output  DW each  read data corrected for pending writes.
REQ-017 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-018 full, empty  output  1 each  count==DEPTH and count==0 respectively.

Function
REQ-019 The queue SHALL be a circular FIFO: head pointer, tail pointer and count, with pointers wrapping modulo DEPTH.
REQ-020 in_ready SHALL equal !full, combinationally; it SHALL NOT depend on drain_en or in_valid.
REQ-021 Accept: in_valid && in_ready at a rising edge with in_reg!=0 SHALL write {in_reg, in_data} at tail and advance tail by 1.
REQ-022 An accepted request with in_reg==0 SHALL be consumed and discarded: no enqueue, and no change to tail or count.
REQ-023 wr_en SHALL equal drain_en && !empty, combinationally.
REQ-024 write_reg and write_data SHALL equal the head entry fields whenever !empty, and SHALL be 0 when empty.
REQ-025 Pop: wr_en high at a rising edge SHALL advance head by 1; the register file commits the write on the falling edge within the same cycle.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and move both pointers.
REQ-027 When full, in_ready SHALL stay 0 even if a pop occurs in that cycle; no same-cycle refill.
REQ-028 Minimum latency SHALL be one cycle: a request accepted at edge N is presented on write_reg/write_data in cycle N+1.
REQ-029 Entries SHALL drain in acceptance order.
REQ-030 Multiple pending entries to the same register SHALL all be retained and written in order.
REQ-031 fwd_dataK SHALL equal the data of the youngest valid entry with reg==rd_addrK, head entry included, and SHALL otherwise equal rf_dataK. Combinational; K=1,2.
REQ-032 Forwarding SHALL NOT bypass the in_* port; a request not yet accepted is invisible to fwd_data.
REQ-033 rd_addrK==0 SHALL return rf_dataK unmodified.
REQ-034 The implementation SHALL evaluate entry validity from the pointers and count, so wrapped occupancy is handled correctly.

Reset
REQ-035 With rst_n low at a rising edge: head=0, tail=0, count=0; hence empty=1, full=0, in_ready=1, wr_en=0, write_reg=0, write_data=0.
REQ-036 Reset SHALL override a simultaneous push or pop, and all pending entries SHALL be lost.
REQ-037 After reset, fwd_dataK SHALL equal rf_dataK.
REQ-038 Entry storage contents SHALL be don't-care after reset.

Verification
REQ-039 Single write: push (r3, 16'h00AA) with drain_en=1. Next cycle: wr_en=1, write_reg=3, write_data=16'h00AA. The following cycle: empty=1.
REQ-040 Fill and stall: drain_en=0 with 4 pushes to r1..r4. Then full=1 and in_ready=0, and a fifth in_valid is not accepted. Raising drain_en drains r1, r2, r3, r4 on consecutive cycles.
REQ-041 Forwarding youngest: drain_en=0, push (r5, 16'h1111) then (r5, 16'h2222), with rf_data1=16'h0005 and rd_addr1=5. fwd_data1 is 16'h2222; rd_addr2=6 gives rf_data2.
REQ-042 Register 0: push (r0, 16'hFFFF). in_ready=1 and count stays 0; wr_en never asserts.
REQ-043 Simultaneous push/pop at count=2 over 10 cycles, wrapping the pointers. count stays 2 and the data order is preserved.
REQ-044 Reset mid-operation: rst_n=0 with count=3. The next cycle shows count=0, empty=1, wr_en=0, and fwd_data equal to rf_data.
